// File: rtl/inst_mem_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package inst_load_pkg;

  localparam int          COUNT_W  = 16;
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    WRITE  = 3'd4,
    FILL   = 3'd5,
    DONE   = 3'd6
  } load_state_t;

  // Byte address of word idx relative to base.
  function automatic logic [63:0] word_addr(input logic [63:0] base,
                                            input logic [COUNT_W-1:0] idx);
    return base + {46'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/inst_mem_loader_if.sv
// Byte stream in and word-write port out of the program loader.
interface inst_mem_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [31:0] mem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/inst_mem_loader_assembler.sv
// Little-endian 4-byte shift buffer; the assembled word is presented together
// with the 4th byte so the loader can register it on that same edge.
module byte_word_assembler (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [23:0] buf_r;
  logic [1:0]  cnt_r;

  assign word       = {byte_data, buf_r};
  assign word_valid = byte_valid && (cnt_r == 2'd3);

  // Bytes enter at the top so the first one settles in the lowest lane.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      buf_r <= 24'd0;
      cnt_r <= 2'd0;
    end else if (clear) begin
      buf_r <= 24'd0;
      cnt_r <= 2'd0;
    end else if (byte_valid) begin
      buf_r <= {byte_data, buf_r[23:8]};
      cnt_r <= cnt_r + 2'd1;
    end
  end

endmodule

// File: rtl/inst_mem_loader.sv
// Program loader: length-prefixed byte stream -> word writes, then NOP padding
// up to the end of instruction memory while the core is held off.
module inst_mem_loader
  import inst_load_pkg::*;
#(
  parameter int          MEM_BYTES = 200,
  parameter int          BASE_ADDR = 0,
  parameter logic [31:0] NOP_WORD  = NOP_INSN
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  inst_mem_loader_if.slave    bus,
  output logic                cpu_hold,
  output logic                done,
  output logic                err_overflow
);

  localparam logic [31:0] MAX_WORDS = 32'((MEM_BYTES - BASE_ADDR) / 4);
  localparam logic [63:0] BASE      = 64'(BASE_ADDR);

  load_state_t          state_r;
  logic [COUNT_W-1:0]   count_r;
  logic [COUNT_W-1:0]   idx_r;
  logic                 in_ready_r;
  logic                 mem_we_r;
  logic [63:0]          mem_addr_r;
  logic [31:0]          mem_wdata_r;
  logic                 cpu_hold_r;
  logic                 done_r;
  logic                 err_r;

  logic                 xfer_s;
  logic                 byte_valid_s;
  logic                 clear_s;
  logic [31:0]          word_s;
  logic                 word_valid_s;
  logic [COUNT_W-1:0]   len_s;
  logic [COUNT_W-1:0]   next_idx_s;
  logic [COUNT_W-1:0]   fill_idx_s;
  logic                 fill_room_s;
  logic                 idx_room_s;

  assign xfer_s       = bus.in_valid && in_ready_r;
  assign byte_valid_s = xfer_s && (state_r == DATA);
  assign clear_s      = (state_r == IDLE);
  assign len_s        = {bus.in_data, count_r[7:0]};
  assign next_idx_s   = idx_r + 16'd1;
  // Padding starts at word 0 for an empty program, else after the word just written.
  assign fill_idx_s   = (state_r == LEN_HI) ? idx_r : next_idx_s;
  assign fill_room_s  = ({16'd0, fill_idx_s} < MAX_WORDS);
  assign idx_room_s   = ({16'd0, idx_r} < MAX_WORDS);

  byte_word_assembler u_asm (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (clear_s),
    .byte_valid (byte_valid_s),
    .byte_data  (bus.in_data),
    .word       (word_s),
    .word_valid (word_valid_s)
  );

  // Load sequencer; every output is registered for the state being entered.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      count_r     <= 16'd0;
      idx_r       <= 16'd0;
      in_ready_r  <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= 64'd0;
      mem_wdata_r <= 32'd0;
      cpu_hold_r  <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      mem_we_r <= 1'b0;
      done_r   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r    <= LEN_LO;
            in_ready_r <= 1'b1;
            cpu_hold_r <= 1'b1;
            err_r      <= 1'b0;
            idx_r      <= 16'd0;
            count_r    <= 16'd0;
          end
        end
        LEN_LO: begin
          if (xfer_s) begin
            count_r[7:0] <= bus.in_data;
            state_r      <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (xfer_s) begin
            count_r[15:8] <= bus.in_data;
            if ({16'd0, len_s} > MAX_WORDS) begin
              err_r <= 1'b1;
            end
            if (len_s == 16'd0) begin
              in_ready_r <= 1'b0;
              if (fill_room_s) begin
                state_r     <= FILL;
                mem_we_r    <= 1'b1;
                mem_addr_r  <= word_addr(BASE, fill_idx_s);
                mem_wdata_r <= NOP_WORD;
              end else begin
                state_r    <= DONE;
                done_r     <= 1'b1;
                cpu_hold_r <= 1'b0;
              end
            end else begin
              state_r <= DATA;
            end
          end
        end
        DATA: begin
          if (word_valid_s) begin
            state_r    <= WRITE;
            in_ready_r <= 1'b0;
            // Words beyond the memory are still consumed, just never written.
            if (idx_room_s) begin
              mem_we_r    <= 1'b1;
              mem_addr_r  <= word_addr(BASE, idx_r);
              mem_wdata_r <= word_s;
            end
          end
        end
        WRITE, FILL: begin
          idx_r <= next_idx_s;
          if ((state_r == WRITE) && (next_idx_s != count_r)) begin
            state_r    <= DATA;
            in_ready_r <= 1'b1;
          end else if (fill_room_s) begin
            state_r     <= FILL;
            mem_we_r    <= 1'b1;
            mem_addr_r  <= word_addr(BASE, fill_idx_s);
            mem_wdata_r <= NOP_WORD;
          end else begin
            state_r    <= DONE;
            done_r     <= 1'b1;
            cpu_hold_r <= 1'b0;
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r    <= IDLE;
          in_ready_r <= 1'b0;
          cpu_hold_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign cpu_hold      = cpu_hold_r;
  assign done          = done_r;
  assign err_overflow  = err_r;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Self-checking bench for inst_mem_loader: randomized program streams compared
// against a memory-image model derived from the stream bytes.
module tb_inst_mem_loader;

  localparam int          MAXW = 50;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic clk = 1'b0;
  logic reset_n;
  logic start;
  logic cpu_hold;
  logic done;
  logic err_overflow;

  inst_mem_loader_if bus ();

  inst_mem_loader #(.MEM_BYTES(200), .BASE_ADDR(0), .NOP_WORD(32'h0000_0013)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .bus          (bus),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .err_overflow (err_overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0]  stim_q[$];
  logic [63:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic        exp_err;
  logic [63:0] got_addr_q[$];
  logic [31:0] got_data_q[$];
  int          done_cnt;
  int          rdy_we_cnt;
  int          hold_bad;
  bit          stalled;

  // Observe the write port and handshake rules on the falling edge.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      got_addr_q.push_back(bus.mem_addr);
      got_data_q.push_back(bus.mem_wdata);
      if (bus.in_ready !== 1'b0) rdy_we_cnt++;
      if (cpu_hold !== 1'b1) hold_bad++;
    end
    if (done === 1'b1) begin
      done_cnt++;
      if (cpu_hold !== 1'b0) hold_bad++;
    end
  end

  // Expected memory image: payload words (clipped to capacity) then NOP to the end.
  task automatic model_stream();
    int n;
    exp_addr_q.delete();
    exp_data_q.delete();
    n = int'({stim_q[1], stim_q[0]});
    for (int i = 0; i < n && i < MAXW; i++) begin
      exp_addr_q.push_back(64'(4 * i));
      exp_data_q.push_back({stim_q[2+4*i+3], stim_q[2+4*i+2], stim_q[2+4*i+1], stim_q[2+4*i]});
    end
    for (int i = n; i < MAXW; i++) begin
      exp_addr_q.push_back(64'(4 * i));
      exp_data_q.push_back(NOP);
    end
    exp_err = (n > MAXW);
  endtask

  task automatic build_random(input int n);
    logic [31:0] w;
    stim_q.delete();
    stim_q.push_back(8'(n));
    stim_q.push_back(8'(n >> 8));
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      for (int b = 0; b < 4; b++) stim_q.push_back(8'(w >> (8 * b)));
    end
  endtask

  task automatic clear_mon();
    got_addr_q.delete();
    got_data_q.delete();
    done_cnt   = 0;
    rdy_we_cnt = 0;
    hold_bad   = 0;
    stalled    = 1'b0;
  endtask

  task automatic start_pulse();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic send_stream(input bit throttle, input int inj_idx, input int limit);
    int ptr = 0;
    int cyc = 0;
    bit tog = 1'b1;
    bit injd = 1'b0;
    bit xfer;
    while (ptr < limit && cyc < 3000) begin
      bus.in_valid = throttle ? tog : 1'b1;
      tog = !tog;
      bus.in_data = stim_q[ptr];
      if (ptr == inj_idx && !injd) begin
        start = 1'b1;
        injd  = 1'b1;
      end else begin
        start = 1'b0;
      end
      xfer = bus.in_valid && bus.in_ready;
      @(negedge clk);
      cyc++;
      if (xfer) ptr++;
    end
    bus.in_valid = 1'b0;
    start = 1'b0;
    if (ptr < limit) stalled = 1'b1;
  endtask

  task automatic wait_done(input string name);
    int cyc = 0;
    while (done_cnt == 0 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    repeat (3) @(negedge clk);
    total++;
    if (stalled || done_cnt == 0) begin
      bad++;
      $display("FAIL %s_complete: stalled=%0d done_cnt=%0d, want stream consumed and done", name, stalled, done_cnt);
    end
  endtask

  task automatic run_load(input string name, input bit throttle, input int inj_idx);
    clear_mon();
    start_pulse();
    send_stream(throttle, inj_idx, stim_q.size());
    wait_done(name);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); end
    total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL rst_mem_we: got %b want 0", bus.mem_we); end
    total++; if (cpu_hold !== 1'b0 || done !== 1'b0 || err_overflow !== 1'b0) begin
      bad++; $display("FAIL rst_flags: hold=%b done=%b err=%b want 000", cpu_hold, done, err_overflow);
    end
    total++; if (bus.mem_addr !== 64'd0 || bus.mem_wdata !== 32'd0) begin
      bad++; $display("FAIL rst_bus: addr=%h data=%h want 0", bus.mem_addr, bus.mem_wdata);
    end
  endtask

  task automatic test_load_n2();
    stim_q = '{8'h02, 8'h00, 8'h93, 8'h84, 8'h14, 8'h00, 8'hb3, 8'h84, 8'h9a, 8'h00};
    model_stream();
    run_load("n2", 1'b0, -1);
    total++; if (got_addr_q.size() != exp_addr_q.size()) begin
      bad++; $display("FAIL n2_count: got %0d writes want %0d", got_addr_q.size(), exp_addr_q.size());
    end else begin
      for (int i = 0; i < got_addr_q.size(); i++) begin
        total++; if (got_addr_q[i] !== exp_addr_q[i] || got_data_q[i] !== exp_data_q[i]) begin
          bad++; $display("FAIL n2_write%0d: got %h@%h want %h@%h", i, got_data_q[i], got_addr_q[i], exp_data_q[i], exp_addr_q[i]);
        end
      end
      total++; if (got_data_q[0] !== 32'h0014_8493 || got_data_q[1] !== 32'h009a_84b3) begin
        bad++; $display("FAIL n2_words: got %h %h want 00148493 009a84b3", got_data_q[0], got_data_q[1]);
      end
    end
    total++; if (done_cnt != 1 || hold_bad != 0 || cpu_hold !== 1'b0) begin
      bad++; $display("FAIL n2_done_hold: done_cnt=%0d hold_bad=%0d hold=%b want 1 0 0", done_cnt, hold_bad, cpu_hold);
    end
  endtask

  task automatic test_zero();
    stim_q = '{8'h00, 8'h00};
    model_stream();
    run_load("zero", 1'b0, -1);
    total++; if (got_addr_q.size() != exp_addr_q.size()) begin
      bad++; $display("FAIL zero_count: got %0d writes want %0d", got_addr_q.size(), exp_addr_q.size());
    end else begin
      for (int i = 0; i < got_addr_q.size(); i++) begin
        total++; if (got_addr_q[i] !== exp_addr_q[i] || got_data_q[i] !== exp_data_q[i]) begin
          bad++; $display("FAIL zero_write%0d: got %h@%h want %h@%h", i, got_data_q[i], got_addr_q[i], exp_data_q[i], exp_addr_q[i]);
        end
      end
    end
    total++; if (done_cnt != 1 || err_overflow !== 1'b0) begin
      bad++; $display("FAIL zero_done_err: done_cnt=%0d err=%b want 1 0", done_cnt, err_overflow);
    end
  endtask

  // Overflow load with a start pulse injected mid-DATA that must be ignored.
  task automatic test_overflow();
    build_random(51);
    model_stream();
    run_load("ovf", 1'b0, 10);
    total++; if (got_addr_q.size() != exp_addr_q.size()) begin
      bad++; $display("FAIL ovf_count: got %0d writes want %0d", got_addr_q.size(), exp_addr_q.size());
    end else begin
      for (int i = 0; i < got_addr_q.size(); i++) begin
        total++; if (got_addr_q[i] !== exp_addr_q[i] || got_data_q[i] !== exp_data_q[i]) begin
          bad++; $display("FAIL ovf_write%0d: got %h@%h want %h@%h", i, got_data_q[i], got_addr_q[i], exp_data_q[i], exp_addr_q[i]);
        end
      end
    end
    total++; if (err_overflow !== exp_err || done_cnt != 1) begin
      bad++; $display("FAIL ovf_err_done: err=%b done_cnt=%0d want %b 1", err_overflow, done_cnt, exp_err);
    end
  endtask

  task automatic test_restart_clears_err();
    stim_q = '{8'h00, 8'h00};
    model_stream();
    clear_mon();
    start_pulse();
    total++; if (err_overflow !== 1'b0 || cpu_hold !== 1'b1) begin
      bad++; $display("FAIL restart_clear: err=%b hold=%b want 0 1", err_overflow, cpu_hold);
    end
    send_stream(1'b0, -1, stim_q.size());
    wait_done("restart");
    total++; if (got_addr_q.size() != MAXW || done_cnt != 1) begin
      bad++; $display("FAIL restart_load: writes=%0d done_cnt=%0d want %0d 1", got_addr_q.size(), done_cnt, MAXW);
    end
  endtask

  task automatic test_throttle();
    stim_q = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
    model_stream();
    run_load("thr", 1'b1, -1);
    total++; if (got_addr_q.size() != exp_addr_q.size()) begin
      bad++; $display("FAIL thr_count: got %0d writes want %0d", got_addr_q.size(), exp_addr_q.size());
    end else begin
      total++; if (got_addr_q[0] !== 64'd0 || got_data_q[0] !== 32'h0000_0013) begin
        bad++; $display("FAIL thr_first: got %h@%h want 00000013@0", got_data_q[0], got_addr_q[0]);
      end
    end
    total++; if (rdy_we_cnt != 0) begin
      bad++; $display("FAIL thr_ready_low: got %0d write cycles with in_ready=1 want 0", rdy_we_cnt);
    end
  endtask

  task automatic test_start_in_fill();
    int cyc = 0;
    build_random(1);
    model_stream();
    clear_mon();
    start_pulse();
    send_stream(1'b0, -1, stim_q.size());
    while (got_addr_q.size() < 5 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_done("fillstart");
    repeat (4) @(negedge clk);
    total++; if (got_addr_q.size() != exp_addr_q.size() || done_cnt != 1) begin
      bad++; $display("FAIL fillstart_count: writes=%0d done_cnt=%0d want %0d 1", got_addr_q.size(), done_cnt, exp_addr_q.size());
    end
    total++; if (cpu_hold !== 1'b0 || bus.in_ready !== 1'b0 || err_overflow !== 1'b0) begin
      bad++; $display("FAIL fillstart_idle: hold=%b rdy=%b err=%b want 000", cpu_hold, bus.in_ready, err_overflow);
    end
  endtask

  task automatic test_reset_midload();
    build_random(4);
    clear_mon();
    start_pulse();
    send_stream(1'b0, -1, 4);
    reset_n = 1'b0;
    @(negedge clk);
    total++; if (bus.in_ready !== 1'b0 || cpu_hold !== 1'b0 || bus.mem_we !== 1'b0) begin
      bad++; $display("FAIL midrst_outputs: rdy=%b hold=%b we=%b want 000", bus.in_ready, cpu_hold, bus.mem_we);
    end
    reset_n = 1'b1;
    @(negedge clk);
    build_random(2);
    model_stream();
    run_load("midrst", 1'b0, -1);
    total++; if (got_addr_q.size() != exp_addr_q.size()) begin
      bad++; $display("FAIL midrst_count: got %0d writes want %0d", got_addr_q.size(), exp_addr_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        total++; if (got_addr_q[i] !== exp_addr_q[i] || got_data_q[i] !== exp_data_q[i]) begin
          bad++; $display("FAIL midrst_write%0d: got %h@%h want %h@%h", i, got_data_q[i], got_addr_q[i], exp_data_q[i], exp_addr_q[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    int n;
    bit thr;
    for (int it = 0; it < 5; it++) begin
      n   = $urandom_range(0, 55);
      thr = 1'($urandom_range(0, 1));
      build_random(n);
      model_stream();
      run_load("rand", thr, -1);
      total++; if (got_addr_q.size() != exp_addr_q.size()) begin
        bad++; $display("FAIL rand%0d_count: n=%0d got %0d writes want %0d", it, n, got_addr_q.size(), exp_addr_q.size());
      end else begin
        for (int i = 0; i < got_addr_q.size(); i++) begin
          total++; if (got_addr_q[i] !== exp_addr_q[i] || got_data_q[i] !== exp_data_q[i]) begin
            bad++; $display("FAIL rand%0d_write%0d: got %h@%h want %h@%h", it, i, got_data_q[i], got_addr_q[i], exp_data_q[i], exp_addr_q[i]);
          end
        end
      end
      total++; if (err_overflow !== exp_err || done_cnt != 1 || hold_bad != 0 || rdy_we_cnt != 0) begin
        bad++; $display("FAIL rand%0d_flags: err=%b done_cnt=%0d hold_bad=%0d rdy_we=%0d want %b 1 0 0",
                        it, err_overflow, done_cnt, hold_bad, rdy_we_cnt, exp_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_n2();
    test_zero();
    test_overflow();
    test_restart_clears_err();
    test_throttle();
    test_start_in_fill();
    test_reset_midload();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
